key_event_scheduler: RTL and testbench

- Collects single-cycle press pulses from up to NUM_KEYS key debouncer instances.
- Latches each press as pending and shares one event channel among all keys with round-robin arbitration.
- Buffers granted key codes in a small first-word-fall-through FIFO and presents them to a consumer with a valid/ready handshake.
- Enforces a power-up blanking window that discards debouncer glitches after reset.

---
 rtl/key_pkg.sv | 39 +++
 rtl/key_event_scheduler_if.sv | 52 +++++
 rtl/key_event_fifo.sv | 84 ++++++++
 rtl/key_event_scheduler.sv | 143 ++++++++++++++
 tb/tb_key_event_scheduler.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_pkg
//  Description : Shared constants and width helpers for the key event
//                scheduler and the debouncer top-level wiring.
//  Revision    : 1.0 - initial release
// ============================================================================
package key_pkg;

    // Default build-time sizing shared with the debouncer array wiring
    localparam int c_default_num_keys    = 4;
    localparam int c_default_fifo_depth  = 4;
    localparam int c_default_init_cycles = 5000;

    // Ceiling log2; clog2(1) = 0
    function automatic int clog2(input int value);
        int v_rem;
        int v_res;
        v_rem = value - 1;
        v_res = 0;
        while (v_rem > 0) begin
            v_res = v_res + 1;
            v_rem = v_rem >> 1;
        end
        return v_res;
    endfunction

    // Key code width: enough bits for NUM_KEYS indices, never narrower than 1
    function automatic int code_width(input int num_keys);
        return (clog2(num_keys) < 1) ? 1 : clog2(num_keys);
    endfunction

    // FIFO occupancy width: must be able to represent the full depth itself
    function automatic int count_width(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage : key_pkg
`default_nettype wire

// File: rtl/key_event_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : key_event_scheduler_if
//  Description : Key press inputs, event handshake and status bundle for the
//                key event scheduler. master = scheduler, slave = consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface key_event_scheduler_if #(
    parameter int NUM_KEYS   = key_pkg::c_default_num_keys,
    parameter int FIFO_DEPTH = key_pkg::c_default_fifo_depth
);
    import key_pkg::*;

    localparam int c_code_w = code_width(NUM_KEYS);
    localparam int c_cnt_w  = count_width(FIFO_DEPTH);

    logic [NUM_KEYS-1:0] key_press;
    logic [c_code_w-1:0] ev_code;
    logic                ev_valid;
    logic                ev_ready;
    logic [NUM_KEYS-1:0] pending;
    logic [c_cnt_w-1:0]  fifo_count;
    logic                init_done;
    logic                overflow;
    logic                ovf_clr;

    modport master (
        input  key_press,
        input  ev_ready,
        input  ovf_clr,
        output ev_code,
        output ev_valid,
        output pending,
        output fifo_count,
        output init_done,
        output overflow
    );

    modport slave (
        output key_press,
        output ev_ready,
        output ovf_clr,
        input  ev_code,
        input  ev_valid,
        input  pending,
        input  fifo_count,
        input  init_done,
        input  overflow
    );

endinterface : key_event_scheduler_if
`default_nettype wire

// File: rtl/key_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : key_event_fifo
//  Description : Small first-word-fall-through FIFO for granted key codes.
//                dout shows the head entry and reads as zero when empty.
//                DEPTH must be a power of two so pointers wrap naturally.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_event_fifo
    import key_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = c_default_fifo_depth
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [WIDTH-1:0]              din,
    input  logic                          pop,
    output logic [WIDTH-1:0]              dout,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          full,
    output logic                          empty
);

    localparam int c_ptr_w = clog2(DEPTH);
    localparam int c_cnt_w = count_width(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    // Status flags are decoded from the registered occupancy only
    assign empty     = (r_count == '0);
    assign full      = (r_count == c_cnt_w'(DEPTH));
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign count     = r_count;
    assign dout      = empty ? '0 : r_mem[r_rd_ptr];

    // Storage array: written at the tail on an accepted push
    always_ff @(posedge clk or posedge rst) begin : p_storage
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Head/tail pointers advance on accepted pop/push and wrap modulo DEPTH
    always_ff @(posedge clk or posedge rst) begin : p_pointers
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy: simultaneous push and pop leave it unchanged
    always_ff @(posedge clk or posedge rst) begin : p_count
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : key_event_fifo
`default_nettype wire

// File: rtl/key_event_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : key_event_scheduler
//  Description : Latches debounced key press pulses as pending, arbitrates
//                them round-robin into an event FIFO and presents key codes
//                over a valid/ready handshake. Presses are ignored during a
//                power-up blanking window after reset release.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_event_scheduler
    import key_pkg::*;
#(
    parameter int NUM_KEYS    = c_default_num_keys,
    parameter int FIFO_DEPTH  = c_default_fifo_depth,
    parameter int INIT_CYCLES = c_default_init_cycles
) (
    input  logic                  clk,
    input  logic                  rst,
    key_event_scheduler_if.master bus
);

    localparam int                  c_code_w   = code_width(NUM_KEYS);
    localparam int                  c_cnt_w    = count_width(FIFO_DEPTH);
    localparam int                  c_init_w   = clog2(INIT_CYCLES) + 1;
    localparam logic [c_code_w-1:0] c_last_idx = c_code_w'(NUM_KEYS - 1);
    localparam logic [c_init_w-1:0] c_init_end = c_init_w'(INIT_CYCLES - 1);

    logic [NUM_KEYS-1:0] r_pending;
    logic [c_code_w-1:0] r_last_grant;
    logic [c_init_w-1:0] r_init_cnt;
    logic                r_init_done;
    logic                r_overflow;

    logic [c_code_w-1:0] w_scan_idx;
    logic                w_found;
    logic [c_code_w-1:0] w_grant_idx;
    logic                w_grant_valid;
    logic [NUM_KEYS-1:0] w_grant_vec;
    logic                w_coalesce;
    logic                w_pop;
    logic [c_code_w-1:0] w_fifo_dout;
    logic [c_cnt_w-1:0]  w_fifo_count;
    logic                w_fifo_full;
    logic                w_fifo_empty;

    // Round-robin search starting one past the last grant; only grants when
    // the registered FIFO occupancy shows room, so a same-cycle pop never
    // makes room for a push
    always_comb begin : p_arbiter
        w_scan_idx  = r_last_grant;
        w_found     = 1'b0;
        w_grant_idx = '0;
        for (int off = 0; off < NUM_KEYS; off++) begin
            if (w_scan_idx == c_last_idx) begin
                w_scan_idx = '0;
            end else begin
                w_scan_idx = w_scan_idx + 1'b1;
            end
            if (!w_found && r_pending[w_scan_idx]) begin
                w_found     = 1'b1;
                w_grant_idx = w_scan_idx;
            end
        end
        w_grant_valid = w_found & ~w_fifo_full;
    end

    // One-hot view of this cycle's grant for the pending clear
    always_comb begin : p_grant_decode
        w_grant_vec = '0;
        if (w_grant_valid) begin
            w_grant_vec[w_grant_idx] = 1'b1;
        end
    end

    // A press landing on a key that is still pending and not being granted
    // merges with the earlier press, which loses an event
    assign w_coalesce = r_init_done & (|(bus.key_press & r_pending & ~w_grant_vec));
    assign w_pop      = ~w_fifo_empty & bus.ev_ready;

    // Pending latch and round-robin pointer; a new press wins over a clear
    always_ff @(posedge clk or posedge rst) begin : p_pending
        if (rst) begin
            r_pending    <= '0;
            r_last_grant <= c_last_idx;
        end else begin
            if (r_init_done) begin
                r_pending <= bus.key_press | (r_pending & ~w_grant_vec);
            end
            if (w_grant_valid) begin
                r_last_grant <= w_grant_idx;
            end
        end
    end

    // Blanking window: count edges after reset release until the last one
    always_ff @(posedge clk or posedge rst) begin : p_blanking
        if (rst) begin
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
        end else if (!r_init_done) begin
            if (r_init_cnt == c_init_end) begin
                r_init_done <= 1'b1;
            end else begin
                r_init_cnt <= r_init_cnt + 1'b1;
            end
        end
    end

    // Sticky lost-press flag; a new loss takes priority over the clear
    always_ff @(posedge clk or posedge rst) begin : p_overflow
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_coalesce) begin
            r_overflow <= 1'b1;
        end else if (bus.ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    key_event_fifo #(
        .WIDTH (c_code_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_grant_valid),
        .din   (w_grant_idx),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .count (w_fifo_count),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    assign bus.ev_code    = w_fifo_dout;
    assign bus.ev_valid   = ~w_fifo_empty;
    assign bus.fifo_count = w_fifo_count;
    assign bus.pending    = r_pending;
    assign bus.init_done  = r_init_done;
    assign bus.overflow   = r_overflow;

endmodule : key_event_scheduler
`default_nettype wire

// File: tb/tb_key_event_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_event_scheduler
//  Description : Scoreboard bench for key_event_scheduler. A reference model
//                tracks pending keys, FIFO occupancy and the blanking window
//                and queues expected key codes; a monitor pops them on every
//                DUT handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_event_scheduler;

    localparam int NK = 4;
    localparam int FD = 4;
    localparam int IC = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit m_pend [NK];
    int m_last  = NK - 1;
    int m_count = 0;
    int m_edges = 0;
    bit m_ovf   = 1'b0;
    int exp_q [$];

    key_event_scheduler_if #(.NUM_KEYS(NK), .FIFO_DEPTH(FD)) bus ();

    key_event_scheduler #(
        .NUM_KEYS    (NK),
        .FIFO_DEPTH  (FD),
        .INIT_CYCLES (IC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic logic [NK-1:0] pend_vec();
        logic [NK-1:0] v;
        v = '0;
        for (int i = 0; i < NK; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NK; i++) m_pend[i] = 1'b0;
        m_last  = NK - 1;
        m_count = 0;
        m_edges = 0;
        m_ovf   = 1'b0;
        exp_q.delete();
    endtask

    // One clock edge of the behavioural rules
    task automatic model_step();
        bit accept;
        bit popped;
        bit ovf_set;
        bit press;
        int g;
        int c;
        accept  = (m_edges >= IC);
        popped  = (m_count > 0) && bus.ev_ready;
        ovf_set = 1'b0;
        g       = -1;
        if (m_count < FD) begin
            for (int k = 1; k <= NK; k++) begin
                c = (m_last + k) % NK;
                if (g < 0 && m_pend[c]) g = c;
            end
        end
        if (accept) begin
            for (int i = 0; i < NK; i++) begin
                press = bus.key_press[i];
                if (press && m_pend[i] && g != i) ovf_set = 1'b1;
                m_pend[i] = press || (m_pend[i] && g != i);
            end
        end
        if (g >= 0) begin
            exp_q.push_back(g);
            m_last  = g;
            m_count = m_count + 1;
        end
        if (popped) m_count = m_count - 1;
        if (ovf_set) m_ovf = 1'b1;
        else if (bus.ovf_clr) m_ovf = 1'b0;
        m_edges = m_edges + 1;
    endtask

    // Model advances on every rising edge
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst) model_reset();
            else model_step();
        end
    end

    // State checker: compares status outputs with the model
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("init_done",  32'(bus.init_done),  32'(m_edges >= IC));
                check("pending",    32'(bus.pending),    32'(pend_vec()));
                check("fifo_count", 32'(bus.fifo_count), 32'(m_count));
                check("ev_valid",   32'(bus.ev_valid),   32'(m_count > 0));
                check("overflow",   32'(bus.overflow),   32'(m_ovf));
                if (m_count == 0) check("ev_code_empty", 32'(bus.ev_code), 32'd0);
            end
        end
    end

    // Event monitor: every accepted event must match the scoreboard head
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.ev_valid === 1'b1 && bus.ev_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ev_unexpected at %0t: got code %0d, expected no event", $time, bus.ev_code);
                end else begin
                    check("ev_code", 32'(bus.ev_code), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic cycle(input logic [NK-1:0] p, input logic r, input logic c);
        bus.key_press = p;
        bus.ev_ready  = r;
        bus.ovf_clr   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_ev_valid",   32'(bus.ev_valid),   32'd0);
        check("rst_ev_code",    32'(bus.ev_code),    32'd0);
        check("rst_pending",    32'(bus.pending),    32'd0);
        check("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
        check("rst_init_done",  32'(bus.init_done),  32'd0);
        check("rst_overflow",   32'(bus.overflow),   32'd0);
    endtask

    function automatic logic [NK-1:0] rand_press(input int odds);
        logic [NK-1:0] v;
        for (int i = 0; i < NK; i++) v[i] = ($urandom_range(0, odds - 1) == 0);
        return v;
    endfunction

    task automatic random_run(input int n);
        int ready_pct;
        ready_pct = 50;
        for (int k = 0; k < n; k++) begin
            if (k % 64 == 0) ready_pct = $urandom_range(5, 95);
            cycle(rand_press(5), ($urandom_range(0, 99) < ready_pct),
                  ($urandom_range(0, 19) == 0));
        end
    endtask

    initial begin
        bus.key_press = '0;
        bus.ev_ready  = 1'b0;
        bus.ovf_clr   = 1'b0;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;

        // Press during blanking is discarded
        cycle(4'b0000, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0);
        cycle(4'b0100, 1'b0, 1'b0);
        repeat (7) cycle(4'b0000, 1'b0, 1'b0);

        // Single press through to the consumer
        cycle(4'b0010, 1'b1, 1'b0);
        repeat (3) cycle(4'b0000, 1'b1, 1'b0);

        // All keys at once, held back, then drained in round-robin order
        cycle(4'b1111, 1'b0, 1'b0);
        repeat (5) cycle(4'b0000, 1'b0, 1'b0);
        repeat (6) cycle(4'b0000, 1'b1, 1'b0);

        // Alternating keys from two different round-robin positions
        cycle(4'b0101, 1'b1, 1'b0);
        repeat (3) cycle(4'b0000, 1'b1, 1'b0);
        cycle(4'b0101, 1'b1, 1'b0);
        repeat (3) cycle(4'b0000, 1'b1, 1'b0);

        // Full FIFO, coalesced press, overflow clear, room for one more
        cycle(4'b1111, 1'b0, 1'b0);
        repeat (5) cycle(4'b0000, 1'b0, 1'b0);
        cycle(4'b0010, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0);
        cycle(4'b0010, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0010, 1'b0, 1'b1);
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0000, 1'b1, 1'b0);
        repeat (3) cycle(4'b0000, 1'b0, 1'b0);
        repeat (8) cycle(4'b0000, 1'b1, 1'b0);

        random_run(1500);

        // Reset mid-traffic, presses during the new blanking window
        cycle(4'b1111, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0);
        cycle(4'b1000, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < IC + 2; k++) cycle(rand_press(2), 1'b1, 1'b0);

        random_run(1500);

        // Drain and confirm every expected event came out
        repeat (24) cycle(4'b0000, 1'b1, 1'b0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_key_event_scheduler
`default_nettype wire
